// File: rtl/volt_meter_pkg.sv
// Shared types and defaults for the volt-meter datapath.
package volt_meter_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} adc_state_t;

  localparam int ADC_BITS_DEF = 10;

endpackage

// File: rtl/tick_gen.sv
// Free-running divide-by-DIV counter; tick marks its last count, clr restarts it at zero.
module tick_gen
  import volt_meter_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master that reads one MSB-first conversion from a serial ADC per start request.
//   state | meaning
//   IDLE  | cs_n high, waiting for start
//   SETUP | cs_n low, one tick of CS-to-SCLK setup
//   SHIFT | toggle sclk every tick, capture miso on each rising toggle
//   DONE  | one cycle: release cs_n, publish sample, pulse sample_valid
//   HOLD  | two ticks of cs_n high before the next frame may start
module adc_spi_reader
  import volt_meter_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int ADC_BITS  = ADC_BITS_DEF,
  parameter int LEAD_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                miso,
  output logic                cs_n,
  output logic                sclk,
  output logic                busy,
  output logic [ADC_BITS-1:0] sample,
  output logic                sample_valid
);

  localparam int TOTAL = LEAD_BITS + ADC_BITS;
  localparam int TCW   = $clog2(2 * TOTAL);
  localparam int BCW   = $clog2(TOTAL + 1);

  if (CLK_DIV < 2) begin : g_div_check
    $error("adc_spi_reader: CLK_DIV must be at least 2");
  end

  adc_state_t state, next_state;

  logic                tick;
  logic                clr;
  logic [TCW-1:0]      tick_cnt;
  logic [BCW-1:0]      bit_cnt;
  logic [ADC_BITS-1:0] shift_reg;

  // Restart the divider whenever the state changes so every state starts a fresh tick period.
  assign clr = (next_state != state);

  tick_gen #(.DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? SETUP : IDLE;
      SETUP:   next_state = tick ? SHIFT : SETUP;
      SHIFT:   next_state = (tick && tick_cnt == TCW'(2 * TOTAL - 1)) ? DONE : SHIFT;
      DONE:    next_state = HOLD;
      HOLD:    next_state = (tick && tick_cnt == TCW'(1)) ? IDLE : HOLD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      busy         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
    end else begin
      state        <= next_state;
      sample_valid <= 1'b0;

      if (clr) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            // Lead bits fall off the top of the register, leaving only the data bits.
            if (!sclk) begin
              shift_reg <= {shift_reg[ADC_BITS-2:0], miso};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          cs_n         <= 1'b1;
          sample       <= shift_reg;
          sample_valid <= 1'b1;
        end
        HOLD: begin
          if (next_state == IDLE) begin
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (CLK_DIV 4 and 2) driven by a behavioural ADC model
// with a scoreboard of expected samples.
module tb_adc_spi_reader;

  localparam int NB = 13;

  typedef struct {
    int         inst;
    logic [9:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       start;
  logic [1:0]       miso;
  logic [1:0]       cs_n;
  logic [1:0]       sclk;
  logic [1:0]       busy;
  logic [1:0]       sv;
  logic [1:0][9:0]  sample;
  logic [1:0][12:0] frame_word;

  adc_spi_reader #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(rst[0]), .start(start[0]), .miso(miso[0]), .cs_n(cs_n[0]),
    .sclk(sclk[0]), .busy(busy[0]), .sample(sample[0]), .sample_valid(sv[0])
  );

  adc_spi_reader #(.CLK_DIV(2)) dut_div2 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .miso(miso[1]), .cs_n(cs_n[1]),
    .sclk(sclk[1]), .busy(busy[1]), .sample(sample[1]), .sample_valid(sv[1])
  );

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  int       rises[2];
  int       vcnt[2];
  int       cs_run[2];
  int       last_gap[2];
  int       bit_idx[2];
  time      vtime[2];
  bit [1:0] prev_cs;
  bit [1:0] prev_sclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ADC model (drives miso after cs_n falls and after each sclk fall) plus output monitors.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic [3:0] bi;
      exp_t       e;
      if (prev_cs[g] && !cs_n[g]) begin
        miso[g]    <= frame_word[g][12];
        bit_idx[g] <= 1;
      end else if (!cs_n[g] && prev_sclk[g] && !sclk[g]) begin
        if (bit_idx[g] < NB) begin
          bi = 4'(NB - 1 - bit_idx[g]);
          miso[g] <= frame_word[g][bi];
        end else begin
          miso[g] <= 1'b0;
        end
        bit_idx[g] <= bit_idx[g] + 1;
      end
      if (!prev_sclk[g] && sclk[g] === 1'b1) rises[g] <= rises[g] + 1;
      if (cs_n[g] === 1'b1) begin
        cs_run[g] <= cs_run[g] + 1;
      end else begin
        if (cs_run[g] > 0) last_gap[g] <= cs_run[g];
        cs_run[g] <= 0;
      end
      if (sv[g] === 1'b1) begin
        vcnt[g]  <= vcnt[g] + 1;
        vtime[g] <= $time - 5;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_inst", 32'(g), 32'(e.inst));
          chk("sb_sample", 32'(sample[g]), 32'(e.val));
        end
      end
      prev_cs[g]   <= (cs_n[g] === 1'b1);
      prev_sclk[g] <= (sclk[g] === 1'b1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int g, output time t0);
    start[g] = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_vcnt(input int g, input int target, input int budget);
    for (int k = 0; k < budget && vcnt[g] < target; k++) cyc(1);
    chk("valid_wait", 32'(vcnt[g] >= target), 32'd1);
  endtask

  task automatic wait_idle(input int g, input int budget);
    for (int k = 0; k < budget && busy[g] !== 1'b0; k++) cyc(1);
    chk("idle_wait", 32'(busy[g]), 32'd0);
  endtask

  task automatic do_frame(input int g, input logic [12:0] w, input int d);
    int  r0, v0;
    time t0;
    r0 = rises[g];
    v0 = vcnt[g];
    frame_word[g] = w;
    sb_q.push_back('{inst: g, val: w[9:0]});
    start_pulse(g, t0);
    chk("busy_after_start", 32'(busy[g]), 32'd1);
    wait_vcnt(g, v0 + 1, 400);
    chk("latency", 32'(vtime[g] - t0), 32'(10 * (d * 27 + 1)));
    wait_idle(g, 100);
    cyc(4);
    chk("sclk_rises", 32'(rises[g] - r0), 32'd13);
    chk("valid_pulses", 32'(vcnt[g] - v0), 32'd1);
    chk("sample_held", 32'(sample[g]), 32'(w[9:0]));
  endtask

  task automatic busy_start_test(input int g, input int d);
    int          r0, v0;
    time         t0;
    logic [12:0] w;
    w = {3'b000, 10'h16B};
    r0 = rises[g];
    v0 = vcnt[g];
    frame_word[g] = w;
    sb_q.push_back('{inst: g, val: w[9:0]});
    start_pulse(g, t0);
    cyc(19);
    start[g] = 1'b1;
    cyc(1);
    start[g] = 1'b0;
    cyc(d * 27 - 20);
    chk("done_cycle_cs", 32'(cs_n[g]), 32'd0);
    chk("done_cycle_valid", 32'(sv[g]), 32'd0);
    start[g] = 1'b1;
    cyc(1);
    start[g] = 1'b0;
    chk("valid_after_done", 32'(sv[g]), 32'd1);
    cyc(2 * d - 1);
    chk("busy_before_hold_exit", 32'(busy[g]), 32'd1);
    cyc(1);
    chk("busy_at_hold_exit", 32'(busy[g]), 32'd0);
    cyc(40);
    chk("ignored_start_rises", 32'(rises[g] - r0), 32'd13);
    chk("ignored_start_valids", 32'(vcnt[g] - v0), 32'd1);
  endtask

  task automatic held_start_test(input int g, input int d);
    int          r0, v0;
    logic [12:0] w;
    w = {3'b101, 10'h1C3};
    r0 = rises[g];
    v0 = vcnt[g];
    frame_word[g] = w;
    for (int f = 0; f < 3; f++) sb_q.push_back('{inst: g, val: w[9:0]});
    start[g] = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      wait_vcnt(g, v0 + f, 400);
      if (f >= 2) chk("cs_gap", 32'(last_gap[g] >= 2 * d), 32'd1);
    end
    start[g] = 1'b0;
    wait_idle(g, 100);
    cyc(20);
    chk("held_rises", 32'(rises[g] - r0), 32'd39);
    chk("held_valids", 32'(vcnt[g] - v0), 32'd3);
  endtask

  task automatic reset_mid_frame_test(input int g, input int d);
    int  r0, v0;
    time t0;
    r0 = rises[g];
    v0 = vcnt[g];
    frame_word[g] = {3'b000, 10'h155};
    start_pulse(g, t0);
    for (int k = 0; k < 200 && rises[g] < r0 + 5; k++) cyc(1);
    chk("rise5_wait", 32'(rises[g] - r0), 32'd5);
    chk("pre_rst_cs", 32'(cs_n[g]), 32'd0);
    chk("pre_rst_sclk", 32'(sclk[g]), 32'd1);
    rst[g] = 1'b0;
    #1;
    chk("rst_cs_async", 32'(cs_n[g]), 32'd1);
    chk("rst_sclk_async", 32'(sclk[g]), 32'd0);
    chk("rst_busy", 32'(busy[g]), 32'd0);
    chk("rst_sample", 32'(sample[g]), 32'd0);
    cyc(3);
    rst[g] = 1'b1;
    cyc(30);
    chk("rst_no_valid", 32'(vcnt[g] - v0), 32'd0);
    chk("rst_no_more_sclk", 32'(rises[g] - r0), 32'd5);
    chk("rst_idle_cs", 32'(cs_n[g]), 32'd1);
    do_frame(g, {3'b010, 10'h2D9}, d);
  endtask

  initial begin
    rst        = 2'b00;
    start      = 2'b00;
    frame_word = '0;
    cyc(3);
    for (int g = 0; g < 2; g++) begin
      chk("reset_cs_n", 32'(cs_n[g]), 32'd1);
      chk("reset_sclk", 32'(sclk[g]), 32'd0);
      chk("reset_busy", 32'(busy[g]), 32'd0);
      chk("reset_sample", 32'(sample[g]), 32'd0);
      chk("reset_valid", 32'(sv[g]), 32'd0);
    end
    rst = 2'b11;
    cyc(20);
    for (int g = 0; g < 2; g++) begin
      chk("idle_no_sclk", 32'(rises[g]), 32'd0);
      chk("idle_cs_n", 32'(cs_n[g]), 32'd1);
    end

    do_frame(0, {3'b000, 10'h2A5}, 4);
    do_frame(0, {3'b111, 10'h000}, 4);
    do_frame(0, {3'b000, 10'h3FF}, 4);
    busy_start_test(0, 4);
    held_start_test(0, 4);
    reset_mid_frame_test(0, 4);

    do_frame(1, {3'b000, 10'h2A5}, 2);
    reset_mid_frame_test(1, 2);

    cyc(5);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
